// File: rtl/stim_bridge_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stim_bridge_monitor : measures biphasic stimulation pulses on an H-bridge
// Rev 1.0
// ---------------------------------------------------------------------------
module stim_bridge_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ano_top,
    input  logic             i_ano_bot,
    input  logic             i_cat_top,
    input  logic             i_cat_bot,
    input  logic             i_curr_ena,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ano_width,
    output logic [CNT_W-1:0] o_cat_width,
    output logic [CNT_W-1:0] o_idle_width,
    output logic             o_meas_vld,
    output logic [CNT_W-1:0] o_pulse_cnt,
    output logic             o_shoot_err,
    output logic             o_seq_err,
    output logic             o_imbal_err
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_IDLE = 2'd1,
        S_ANO  = 2'd2,
        S_CAT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_max  = '1;
    localparam logic [CNT_W-1:0] c_zero = '0;
    localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_max) ? v : v + c_one;
    endfunction

    state_t             r_state_q, w_state_d;
    logic [3:0]         r_drv_q;
    logic               r_ena_q;
    logic [CNT_W-1:0]   r_idle_cnt_q, w_idle_cnt_d;
    logic [CNT_W-1:0]   r_ano_cnt_q,  w_ano_cnt_d;
    logic [CNT_W-1:0]   r_cat_cnt_q,  w_cat_cnt_d;
    logic [CNT_W-1:0]   r_pend_q,     w_pend_d;
    logic               r_idle_ok_q,  w_idle_ok_d;
    logic [CNT_W-1:0]   r_ano_w_q,    w_ano_w_d;
    logic [CNT_W-1:0]   r_cat_w_q,    w_cat_w_d;
    logic [CNT_W-1:0]   r_idle_w_q,   w_idle_w_d;
    logic               r_vld_q,      w_vld_d;
    logic [CNT_W-1:0]   r_pcnt_q,     w_pcnt_d;
    logic               r_shoot_q,    w_shoot_d;
    logic               r_seq_q,      w_seq_d;
    logic               r_imbal_q,    w_imbal_d;
    logic               w_set_shoot, w_set_seq;

    // r_drv_q = {ano_top, ano_bot, cat_top, cat_bot}
    logic w_p_shoot, w_p_off, w_p_ano, w_p_cat;
    assign w_p_shoot = (r_drv_q[3] & r_drv_q[2]) | (r_drv_q[1] & r_drv_q[0]);
    assign w_p_off   = (r_drv_q == 4'b0000);
    assign w_p_ano   = (r_drv_q == 4'b1001);
    assign w_p_cat   = (r_drv_q == 4'b0110);

    always_comb begin
        w_state_d    = r_state_q;
        w_idle_cnt_d = r_idle_cnt_q;
        w_ano_cnt_d  = r_ano_cnt_q;
        w_cat_cnt_d  = r_cat_cnt_q;
        w_pend_d     = r_pend_q;
        w_idle_ok_d  = r_idle_ok_q;
        w_ano_w_d    = r_ano_w_q;
        w_cat_w_d    = r_cat_w_q;
        w_idle_w_d   = r_idle_w_q;
        w_vld_d      = 1'b0;
        w_set_shoot  = 1'b0;
        w_set_seq    = 1'b0;

        // Shoot-through outranks a dropped enable so it is always flagged
        if (w_p_shoot) begin
            w_set_shoot = 1'b1;
            w_state_d   = S_WAIT;
        end else if (!r_ena_q) begin
            w_state_d = S_WAIT;
        end else begin
            case (r_state_q)
                S_WAIT: begin
                    if (w_p_off) begin
                        w_state_d    = S_IDLE;
                        w_idle_cnt_d = c_one;
                        w_idle_ok_d  = 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_p_off) begin
                        w_idle_cnt_d = sat_inc(r_idle_cnt_q);
                    end else if (w_p_ano) begin
                        w_state_d   = S_ANO;
                        w_ano_cnt_d = c_one;
                        w_pend_d    = r_idle_ok_q ? r_idle_cnt_q : c_zero;
                    end else if (w_p_cat) begin
                        w_set_seq    = 1'b1;
                        w_idle_cnt_d = c_one;
                    end else begin
                        w_set_seq = 1'b1;
                        w_state_d = S_WAIT;
                    end
                end
                S_ANO: begin
                    if (w_p_ano) begin
                        w_ano_cnt_d = sat_inc(r_ano_cnt_q);
                    end else if (w_p_cat) begin
                        w_state_d   = S_CAT;
                        w_cat_cnt_d = c_one;
                    end else if (w_p_off) begin
                        w_set_seq    = 1'b1;
                        w_state_d    = S_IDLE;
                        w_idle_cnt_d = c_one;
                        w_idle_ok_d  = 1'b1;
                    end else begin
                        w_set_seq = 1'b1;
                        w_state_d = S_WAIT;
                    end
                end
                S_CAT: begin
                    if (w_p_cat) begin
                        w_cat_cnt_d = sat_inc(r_cat_cnt_q);
                    end else if (w_p_off) begin
                        w_state_d    = S_IDLE;
                        w_idle_cnt_d = c_one;
                        w_idle_ok_d  = 1'b1;
                        w_vld_d      = 1'b1;
                        w_ano_w_d    = r_ano_cnt_q;
                        w_cat_w_d    = r_cat_cnt_q;
                        w_idle_w_d   = r_pend_q;
                    end else if (w_p_ano) begin
                        // no OFF gap between the phases, so no idle time to report
                        w_set_seq   = 1'b1;
                        w_state_d   = S_ANO;
                        w_ano_cnt_d = c_one;
                        w_pend_d    = c_zero;
                    end else begin
                        w_set_seq = 1'b1;
                        w_state_d = S_WAIT;
                    end
                end
                default: w_state_d = S_WAIT;
            endcase
        end

        w_shoot_d = w_set_shoot | (r_shoot_q & ~i_clr);
        w_seq_d   = w_set_seq   | (r_seq_q   & ~i_clr);
        w_imbal_d = (w_vld_d & (r_ano_cnt_q != r_cat_cnt_q)) | (r_imbal_q & ~i_clr);
        if (i_clr)
            w_pcnt_d = c_zero;
        else if (w_vld_d)
            w_pcnt_d = r_pcnt_q + c_one;
        else
            w_pcnt_d = r_pcnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q    <= S_WAIT;
            r_drv_q      <= 4'b0000;
            r_ena_q      <= 1'b0;
            r_idle_cnt_q <= c_zero;
            r_ano_cnt_q  <= c_zero;
            r_cat_cnt_q  <= c_zero;
            r_pend_q     <= c_zero;
            r_idle_ok_q  <= 1'b0;
            r_ano_w_q    <= c_zero;
            r_cat_w_q    <= c_zero;
            r_idle_w_q   <= c_zero;
            r_vld_q      <= 1'b0;
            r_pcnt_q     <= c_zero;
            r_shoot_q    <= 1'b0;
            r_seq_q      <= 1'b0;
            r_imbal_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_drv_q      <= {i_ano_top, i_ano_bot, i_cat_top, i_cat_bot};
            r_ena_q      <= i_curr_ena;
            r_idle_cnt_q <= w_idle_cnt_d;
            r_ano_cnt_q  <= w_ano_cnt_d;
            r_cat_cnt_q  <= w_cat_cnt_d;
            r_pend_q     <= w_pend_d;
            r_idle_ok_q  <= w_idle_ok_d;
            r_ano_w_q    <= w_ano_w_d;
            r_cat_w_q    <= w_cat_w_d;
            r_idle_w_q   <= w_idle_w_d;
            r_vld_q      <= w_vld_d;
            r_pcnt_q     <= w_pcnt_d;
            r_shoot_q    <= w_shoot_d;
            r_seq_q      <= w_seq_d;
            r_imbal_q    <= w_imbal_d;
        end
    end

    assign o_ano_width  = r_ano_w_q;
    assign o_cat_width  = r_cat_w_q;
    assign o_idle_width = r_idle_w_q;
    assign o_meas_vld   = r_vld_q;
    assign o_pulse_cnt  = r_pcnt_q;
    assign o_shoot_err  = r_shoot_q;
    assign o_seq_err    = r_seq_q;
    assign o_imbal_err  = r_imbal_q;

endmodule
`default_nettype wire

// File: doc/stim_bridge_monitor.md
STIM_BRIDGE_MONITOR -- requirements
Module: stim_bridge_monitor

Interface
REQ-001 Parameter CNT_W, 16: width of the phase-width, idle-width and pulse counters.
REQ-002 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  reset; asynchronous and active-low.
REQ-004 i_ano_top, i_ano_bot, i_cat_top, i_cat_bot  in  1 each  H-bridge switch drives from the stimulator, same clock domain.
REQ-005 i_curr_ena  in  1  current-source enable from the stimulator.
REQ-006 i_clr  in  1  synchronous clear of sticky flags and pulse count.
REQ-007 o_ano_width, o_cat_width, o_idle_width  out  CNT_W each  last completed anodic, cathodic and preceding-idle widths, in clock cycles.
REQ-008 o_meas_vld  out  1  one-cycle strobe; the three widths were updated this cycle.
REQ-009 o_pulse_cnt  out  CNT_W  completed biphasic pulses.
REQ-010 o_shoot_err, o_seq_err, o_imbal_err  out  1 each  sticky fault flags.

Function
REQ-011 The block SHALL register the five drive inputs once; all decoding uses the registered copies, so it adds 1 cycle of input latency.
REQ-012 Decode: ANO = ano_top&cat_bot with ano_bot=cat_top=0; CAT = cat_top&ano_bot with ano_top=cat_bot=0; OFF = all four 0; SHOOT = (ano_top&ano_bot)|(cat_top&cat_bot); any other pattern = ILLEGAL.
REQ-013 FSM states: S_WAIT, S_IDLE, S_ANO, S_CAT. Reset state is S_WAIT.
REQ-014 S_WAIT: when registered curr_ena=1 and pattern=OFF -> S_IDLE, idle counter loads 1, the idle-valid marker clears.
REQ-015 S_IDLE: OFF -> increment idle counter; ANO -> S_ANO, anodic counter loads 1, idle counter value is latched as pending idle width.
REQ-016 S_ANO: ANO -> increment; CAT -> S_CAT, cathodic counter loads 1; OFF -> S_IDLE with o_seq_err set, idle counter loads 1.
REQ-017 S_CAT: CAT -> increment; OFF -> S_IDLE, idle counter loads 1, and in that same cycle o_meas_vld=1 with the widths updated; ANO -> S_ANO with o_seq_err set and no measurement.
REQ-018 CAT seen in S_IDLE SHALL set o_seq_err; state stays S_IDLE and the idle counter loads 1.
REQ-019 The first pulse after entering S_IDLE from S_WAIT SHALL report o_idle_width=0; later pulses report the full OFF run before the anodic phase.
REQ-020 All width counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 On each o_meas_vld, o_pulse_cnt SHALL increment modulo 2^CNT_W; it wraps from all-ones to 0.
REQ-022 On each o_meas_vld, o_imbal_err SHALL be set if the anodic width differs from the cathodic width.
REQ-023 SHOOT in any state SHALL set o_shoot_err and force S_WAIT; ILLEGAL in S_IDLE, S_ANO or S_CAT SHALL set o_seq_err and force S_WAIT. Neither case produces a measurement.
REQ-024 If registered curr_ena=0 in any state, the FSM SHALL go to S_WAIT, abandon the partial pulse, and produce no strobe. SHOOT is still flagged in this case.
REQ-025 Sticky flags clear only on i_clr or reset. If i_clr and a set condition occur in the same cycle, set wins. i_clr also zeroes o_pulse_cnt, and a simultaneous increment is lost (result 0).
REQ-026 Width outputs SHALL hold their value between strobes.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately set: state S_WAIT, all counters and width outputs 0, o_meas_vld=0, all flags 0, and the input registers 0.
REQ-028 Reset asserted mid-pulse SHALL discard that pulse; the first strobe after release belongs to a pulse started after release.

Verification
REQ-029 curr_ena=1 with the sequence OFF x5, ANO x7, CAT x7, OFF -> o_meas_vld 2 cycles after the first post-CAT OFF sample, widths ano=7, cat=7, idle=0, o_pulse_cnt=1, no flags.
REQ-030 Two consecutive pulses of ANO 7 / CAT 7 separated by OFF x7 -> second strobe reports idle=7, o_pulse_cnt=2.
REQ-031 ANO x5 then CAT x6 -> strobe with ano=5, cat=6 and o_imbal_err=1; the flag survives later balanced pulses until i_clr.
REQ-032 ano_top=ano_bot=1 for 1 cycle during S_ANO -> o_shoot_err=1, state S_WAIT, no strobe; recovery through OFF yields normal measurement.
REQ-033 ANO x2^CNT_W+10 then CAT x3 -> ano=2^CNT_W-1 (saturated), cat=3.
REQ-034 i_curr_ena dropped mid-CAT, and separately i_rst_n pulsed mid-ANO -> no strobe, o_pulse_cnt unchanged (the reset case returns it to 0).
